// File: rtl/button_event_gen.sv
// Turns a debounced button level into registered single-cycle press/release/repeat
// events, a long-press level and a wrapping press counter.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ARM     | after reset; waits for the button to read released
// IDLE    | button released, ready to accept a press
// PRESSED | button down, counting towards long-press
// HELD    | long-press reached, emitting auto-repeat pulses
module button_event_gen #(
   parameter int LONG_CYCLES   = 25_000_000,
   parameter int REPEAT_CYCLES = 5_000_000,
   parameter int COUNT_W       = 8
) (
   input  logic               clk_hifreq,
   input  logic               rst,
   input  logic               btn_level,
   output logic               press_pulse,
   output logic               release_pulse,
   output logic               long_press,
   output logic               repeat_pulse,
   output logic [COUNT_W-1:0] press_count
);

   // Counters keep at least one bit so REPEAT_CYCLES = 1 still elaborates.
   localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
   localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
   localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {ARM, IDLE, PRESSED, HELD} state_t;

   state_t             state, state_nx;
   logic [HW-1:0]      hold_cnt, hold_nx;
   logic [RW-1:0]      rep_cnt, rep_nx;
   logic [COUNT_W-1:0] count_nx;
   logic               press_nx, release_nx, repeat_nx;

   always_ff @(posedge clk_hifreq or posedge rst) begin
      if (rst) begin
         state         <= ARM;
         hold_cnt      <= '0;
         rep_cnt       <= '0;
         press_count   <= '0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         repeat_pulse  <= 1'b0;
         long_press    <= 1'b0;
      end else begin
         state         <= state_nx;
         hold_cnt      <= hold_nx;
         rep_cnt       <= rep_nx;
         press_count   <= count_nx;
         press_pulse   <= press_nx;
         release_pulse <= release_nx;
         repeat_pulse  <= repeat_nx;
         long_press    <= (state_nx == HELD);
      end
   end

   always_comb begin
      state_nx   = state;
      hold_nx    = hold_cnt;
      rep_nx     = rep_cnt;
      count_nx   = press_count;
      press_nx   = 1'b0;
      release_nx = 1'b0;
      repeat_nx  = 1'b0;
      case (state)
         ARM: begin
            if (!btn_level) state_nx = IDLE;
         end
         IDLE: begin
            if (btn_level) begin
               state_nx = PRESSED;
               press_nx = 1'b1;
               count_nx = press_count + 1'b1;
               hold_nx  = '0;
            end
         end
         PRESSED: begin
            // Release takes priority over reaching the long-press threshold.
            if (!btn_level) begin
               state_nx   = IDLE;
               release_nx = 1'b1;
            end else if (hold_cnt == HOLD_LAST) begin
               state_nx  = HELD;
               repeat_nx = 1'b1;
               rep_nx    = '0;
            end else begin
               hold_nx = hold_cnt + 1'b1;
            end
         end
         HELD: begin
            if (!btn_level) begin
               state_nx   = IDLE;
               release_nx = 1'b1;
            end else if (rep_cnt == REP_LAST) begin
               repeat_nx = 1'b1;
               rep_nx    = '0;
            end else begin
               rep_nx = rep_cnt + 1'b1;
            end
         end
         default: state_nx = ARM;
      endcase
   end

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen: vector table for the main sequences plus
// hand-written async-reset and single-cycle-repeat scenarios.
module tb_button_event_gen;

   logic       clk_hifreq = 1'b0;
   logic       rst = 1'b1;
   logic       btn_level = 1'b1;
   logic       btn1 = 1'b0;
   logic       press_pulse, release_pulse, long_press, repeat_pulse;
   logic [2:0] press_count;
   logic       press1, release1, long1, repeat1;
   logic [2:0] count1;

   int checks = 0;
   int errors = 0;

   always #5 clk_hifreq = ~clk_hifreq;

   button_event_gen #(.LONG_CYCLES(8), .REPEAT_CYCLES(4), .COUNT_W(3)) dut (
      .clk_hifreq    (clk_hifreq),
      .rst           (rst),
      .btn_level     (btn_level),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_press    (long_press),
      .repeat_pulse  (repeat_pulse),
      .press_count   (press_count)
   );

   button_event_gen #(.LONG_CYCLES(8), .REPEAT_CYCLES(1), .COUNT_W(3)) dut1 (
      .clk_hifreq    (clk_hifreq),
      .rst           (rst),
      .btn_level     (btn1),
      .press_pulse   (press1),
      .release_pulse (release1),
      .long_press    (long1),
      .repeat_pulse  (repeat1),
      .press_count   (count1)
   );

   typedef struct {
      logic       r;
      logic       b;
      logic       p;
      logic       rl;
      logic       l;
      logic       rp;
      logic [2:0] c;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic b, input logic p, input logic rl,
                      input logic l, input logic rp, input logic [2:0] c);
      vec_t v;
      v.r = r; v.b = b; v.p = p; v.rl = rl; v.l = l; v.rp = rp; v.c = c;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic b);
      @(negedge clk_hifreq);
      rst = r;
      btn_level = b;
      @(posedge clk_hifreq);
      #1;
   endtask

   task automatic chk_all(input string name, input int idx, input logic p, input logic rl,
                          input logic l, input logic rp, input logic [2:0] c);
      chk({name, ".press"}, idx, int'(press_pulse), int'(p));
      chk({name, ".release"}, idx, int'(release_pulse), int'(rl));
      chk({name, ".long"}, idx, int'(long_press), int'(l));
      chk({name, ".repeat"}, idx, int'(repeat_pulse), int'(rp));
      chk({name, ".count"}, idx, int'(press_count), int'(c));
   endtask

   initial begin
      // Reset with button held, then released for one cycle, then pressed.
      for (int i = 0; i < 5; i++) add(1, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0);
      // Hold edges k..k+19 then release at k+20.
      for (int i = 0; i < 20; i++)
         add(0, 1, i == 0, 0, i >= 8, (i == 8 || i == 12 || i == 16), 1);
      add(0, 0, 0, 1, 0, 0, 1);
      // Immediate re-press, released on the long-press threshold edge.
      for (int i = 0; i < 8; i++) add(0, 1, i == 0, 0, 0, 0, 2);
      add(0, 0, 0, 1, 0, 0, 2);
      add(0, 0, 0, 0, 0, 0, 2);
      // Fresh reset, then 9 single-cycle presses wrapping the counter.
      add(1, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 9; i++) begin
         add(0, 1, 1, 0, 0, 0, 3'(i));
         add(0, 0, 0, 1, 0, 0, 3'(i));
      end

      foreach (vecs[i]) begin
         step(vecs[i].r, vecs[i].b);
         chk_all("vec", i, vecs[i].p, vecs[i].rl, vecs[i].l, vecs[i].rp, vecs[i].c);
      end

      // Asynchronous reset in the middle of HELD.
      step(1, 0);
      step(0, 0);
      for (int i = 0; i < 10; i++) step(0, 1);
      chk("async.pre_long", 0, int'(long_press), 1);
      chk("async.pre_count", 0, int'(press_count), 1);
      #3;
      rst = 1'b1;
      #1;
      chk_all("async.now", 0, 0, 0, 0, 0, 0);
      step(1, 1);
      chk_all("async.held", 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 1);
         chk_all("async.arm", i, 0, 0, 0, 0, 0);
      end
      step(0, 0);
      chk_all("async.idle", 0, 0, 0, 0, 0, 0);
      step(0, 1);
      chk_all("async.press", 0, 1, 0, 0, 0, 1);

      // Single-cycle repeat instance: hold 12 edges then release.
      btn1 = 1'b0;
      step(1, 0);
      step(0, 0);
      for (int i = 0; i <= 12; i++) begin
         @(negedge clk_hifreq);
         btn1 = (i < 12);
         @(posedge clk_hifreq);
         #1;
         chk("rep1.repeat", i, int'(repeat1), int'(i >= 8 && i < 12));
         chk("rep1.long", i, int'(long1), int'(i >= 8 && i < 12));
         chk("rep1.release", i, int'(release1), int'(i == 12));
         chk("rep1.press", i, int'(press1), int'(i == 0));
      end
      chk("rep1.count", 0, int'(count1), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
